// File: rtl/cache_refill_ctrl_if.sv
// rtl/cache_refill_ctrl_if.sv - miss, RAM and fill signal bundle for the refill controller
interface cache_refill_ctrl_if #(
    parameter int ADDRESS_WIDTH = 16,
    parameter int DATA_WIDTH    = 32,
    parameter int INDEX_WIDTH   = 4,
    parameter int LINE_WIDTH    = 137
);
    logic                     miss_valid;
    logic [ADDRESS_WIDTH-1:0] miss_addr;
    logic                     miss_ready;
    logic                     stall;
    logic                     mem_req;
    logic [ADDRESS_WIDTH-1:0] mem_addr;
    logic                     mem_rvalid;
    logic [DATA_WIDTH-1:0]    mem_rdata;
    logic                     crit_valid;
    logic [DATA_WIDTH-1:0]    crit_data;
    logic                     fill_valid;
    logic [INDEX_WIDTH-1:0]   fill_index;
    logic [LINE_WIDTH-1:0]    fill_line;

    // Cache/RAM side: raises misses and answers reads
    modport master (
        output miss_valid, miss_addr, mem_rvalid, mem_rdata,
        input  miss_ready, stall, mem_req, mem_addr,
               crit_valid, crit_data, fill_valid, fill_index, fill_line
    );

    // Refill controller side
    modport slave (
        input  miss_valid, miss_addr, mem_rvalid, mem_rdata,
        output miss_ready, stall, mem_req, mem_addr,
               crit_valid, crit_data, fill_valid, fill_index, fill_line
    );
endinterface

// File: rtl/cache_refill_ctrl.sv
// rtl/cache_refill_ctrl.sv - critical-word-first cache line refill controller
module cache_refill_ctrl #(
    parameter int ADDRESS_WIDTH = 16,
    parameter int DATA_WIDTH    = 32,
    parameter int TAG_WIDTH     = 8,
    parameter int INDEX_WIDTH   = 4,
    parameter int LINE_WIDTH    = 1 + TAG_WIDTH + 4 * DATA_WIDTH
) (
    input logic                clk,
    input logic                rst_n,
    cache_refill_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, FETCH, FILL} state_t;

    state_t                 state;
    logic [TAG_WIDTH-1:0]   tag_q;
    logic [INDEX_WIDTH-1:0] index_q;
    logic [1:0]             start_q;
    logic [1:0]             beat_q;
    logic [DATA_WIDTH-1:0]  words_q [4];
    logic [DATA_WIDTH-1:0]  words_next [4];
    logic [1:0]             slot;
    logic                   beat_take;
    logic [LINE_WIDTH-1:0]  line_next;

    // Fetch order wraps naturally in two bits: start+beat mod 4
    assign slot      = start_q + beat_q;
    assign beat_take = (state == FETCH) && bus.mem_rvalid;

    // Handshake outputs decode the state directly so accept costs no extra cycle
    assign bus.miss_ready = (state == IDLE);
    assign bus.stall      = (state != IDLE);

    // Word storage including the beat arriving this cycle, so the last beat
    // can be folded into the fill line on the same edge it is sampled
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            words_next[i] = words_q[i];
        end
        if (beat_take) begin
            words_next[slot] = bus.mem_rdata;
        end
        line_next = {1'b1, tag_q, words_next[3], words_next[2], words_next[1], words_next[0]};
    end

    // Refill FSM with registered RAM, critical-word and fill outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            tag_q          <= '0;
            index_q        <= '0;
            start_q        <= '0;
            beat_q         <= '0;
            for (int i = 0; i < 4; i++) begin
                words_q[i] <= '0;
            end
            bus.mem_req    <= 1'b0;
            bus.mem_addr   <= '0;
            bus.crit_valid <= 1'b0;
            bus.crit_data  <= '0;
            bus.fill_valid <= 1'b0;
            bus.fill_index <= '0;
            bus.fill_line  <= '0;
        end else begin
            bus.crit_valid <= 1'b0;
            bus.fill_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.miss_valid) begin
                        tag_q        <= bus.miss_addr[ADDRESS_WIDTH-1 -: TAG_WIDTH];
                        index_q      <= bus.miss_addr[INDEX_WIDTH+3:4];
                        start_q      <= bus.miss_addr[3:2];
                        beat_q       <= 2'd0;
                        bus.mem_req  <= 1'b1;
                        bus.mem_addr <= {bus.miss_addr[ADDRESS_WIDTH-1:2], 2'b00};
                        state        <= FETCH;
                    end
                end
                FETCH: begin
                    if (bus.mem_rvalid) begin
                        for (int i = 0; i < 4; i++) begin
                            words_q[i] <= words_next[i];
                        end
                        beat_q <= beat_q + 2'd1;
                        if (beat_q == 2'd0) begin
                            bus.crit_data  <= bus.mem_rdata;
                            bus.crit_valid <= 1'b1;
                        end
                        if (beat_q == 2'd3) begin
                            bus.mem_req    <= 1'b0;
                            bus.fill_valid <= 1'b1;
                            bus.fill_index <= index_q;
                            bus.fill_line  <= line_next;
                            state          <= FILL;
                        end else begin
                            bus.mem_addr <= {tag_q, index_q, slot + 2'd1, 2'b00};
                        end
                    end
                end
                FILL: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_cache_refill_ctrl.sv
// tb/tb_cache_refill_ctrl.sv - directed self-checking bench for cache_refill_ctrl
module tb_cache_refill_ctrl;
    logic clk = 1'b0;
    logic rst_n;

    cache_refill_ctrl_if bus ();

    cache_refill_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0]        addr;
        int                 wait_cycles;
        logic [3:0][15:0]   seq;
        int                 crit_cyc;
        logic [31:0]        crit;
        int                 fill_cyc;
        logic [3:0]         idx;
        logic [136:0]       line;
    } vec_t;

    vec_t vecs [4];
    int   checks = 0;
    int   errors = 0;
    int   wait_cfg = 0;
    int   wait_cnt = 0;
    logic spur = 1'b0;

    task automatic chk(input string name, input logic [136:0] act, input logic [136:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // RAM model, called once per negedge: answers after wait_cfg idle cycles per beat
    task automatic ram_step();
        if (bus.mem_req) begin
            if (wait_cnt >= wait_cfg) begin
                bus.mem_rvalid = 1'b1;
                bus.mem_rdata  = {16'hA5A5, bus.mem_addr};
                wait_cnt       = 0;
            end else begin
                bus.mem_rvalid = 1'b0;
                wait_cnt++;
            end
        end else begin
            bus.mem_rvalid = spur;
            bus.mem_rdata  = 32'hDEADBEEF;
            wait_cnt       = 0;
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_miss_ready"}, 137'(bus.miss_ready), 137'(1'b1));
        chk({tag, "_stall"},      137'(bus.stall),      137'(1'b0));
        chk({tag, "_mem_req"},    137'(bus.mem_req),    137'(1'b0));
        chk({tag, "_mem_addr"},   137'(bus.mem_addr),   137'(16'h0));
        chk({tag, "_crit_valid"}, 137'(bus.crit_valid), 137'(1'b0));
        chk({tag, "_crit_data"},  137'(bus.crit_data),  137'(32'h0));
        chk({tag, "_fill_valid"}, 137'(bus.fill_valid), 137'(1'b0));
        chk({tag, "_fill_index"}, 137'(bus.fill_index), 137'(4'h0));
        chk({tag, "_fill_line"},  bus.fill_line,        137'(0));
    endtask

    task automatic run_vector(input int n, input vec_t v);
        int          beat;
        int          crit_cyc;
        int          crit_cnt;
        int          fill_cyc;
        logic [31:0] crit_got;
        logic [3:0]  idx_got;
        logic [136:0] line_got;
        logic        stall_ok;
        logic        addr_ok;
        beat = 0; crit_cyc = 0; crit_cnt = 0; fill_cyc = 0;
        crit_got = '0; idx_got = '0; line_got = '0;
        stall_ok = 1'b1; addr_ok = 1'b1;
        wait_cfg = v.wait_cycles;
        @(negedge clk);
        bus.miss_valid = 1'b1;
        bus.miss_addr  = v.addr;
        ram_step();
        @(posedge clk);
        for (int c = 1; c <= 40 && fill_cyc == 0; c++) begin
            @(negedge clk);
            bus.miss_valid = 1'b0;
            if (!bus.stall) stall_ok = 1'b0;
            if (bus.crit_valid) begin
                crit_cyc = c;
                crit_cnt++;
                crit_got = bus.crit_data;
            end
            if (bus.fill_valid) begin
                fill_cyc = c;
                idx_got  = bus.fill_index;
                line_got = bus.fill_line;
            end
            if (bus.mem_req && beat < 4 && bus.mem_addr !== v.seq[beat]) addr_ok = 1'b0;
            ram_step();
            if (bus.mem_req && bus.mem_rvalid) beat++;
        end
        chk($sformatf("v%0d_addr_seq", n),   137'(addr_ok),  137'(1'b1));
        chk($sformatf("v%0d_stall", n),      137'(stall_ok), 137'(1'b1));
        chk($sformatf("v%0d_crit_cyc", n),   137'(crit_cyc), 137'(v.crit_cyc));
        chk($sformatf("v%0d_crit_cnt", n),   137'(crit_cnt), 137'(1));
        chk($sformatf("v%0d_crit_data", n),  137'(crit_got), 137'(v.crit));
        chk($sformatf("v%0d_fill_cyc", n),   137'(fill_cyc), 137'(v.fill_cyc));
        chk($sformatf("v%0d_fill_index", n), 137'(idx_got),  137'(v.idx));
        chk($sformatf("v%0d_fill_line", n),  line_got,       v.line);
        @(negedge clk);
        chk($sformatf("v%0d_ready_after", n), 137'(bus.miss_ready), 137'(1'b1));
        chk($sformatf("v%0d_stall_after", n), 137'(bus.stall),      137'(1'b0));
        chk($sformatf("v%0d_fill_pulse", n),  137'(bus.fill_valid), 137'(1'b0));
        chk($sformatf("v%0d_line_hold", n),   bus.fill_line,        v.line);
        ram_step();
    endtask

    initial begin
        logic [6:0]   rdy;
        logic         fill_seen;
        int           fill_cyc;
        logic [136:0] line_got;
        logic [3:0]   idx_got;
        logic [31:0]  crit_got;

        vecs[0].addr = 16'h1230; vecs[0].wait_cycles = 0;
        vecs[0].seq  = {16'h123C, 16'h1238, 16'h1234, 16'h1230};
        vecs[0].crit_cyc = 2; vecs[0].crit = 32'hA5A51230; vecs[0].fill_cyc = 5; vecs[0].idx = 4'h3;
        vecs[0].line = {1'b1, 8'h12, 32'hA5A5123C, 32'hA5A51238, 32'hA5A51234, 32'hA5A51230};

        vecs[1].addr = 16'h45E9; vecs[1].wait_cycles = 0;
        vecs[1].seq  = {16'h45E4, 16'h45E0, 16'h45EC, 16'h45E8};
        vecs[1].crit_cyc = 2; vecs[1].crit = 32'hA5A545E8; vecs[1].fill_cyc = 5; vecs[1].idx = 4'hE;
        vecs[1].line = {1'b1, 8'h45, 32'hA5A545EC, 32'hA5A545E8, 32'hA5A545E4, 32'hA5A545E0};

        vecs[2].addr = 16'hBEF4; vecs[2].wait_cycles = 3;
        vecs[2].seq  = {16'hBEF0, 16'hBEFC, 16'hBEF8, 16'hBEF4};
        vecs[2].crit_cyc = 5; vecs[2].crit = 32'hA5A5BEF4; vecs[2].fill_cyc = 17; vecs[2].idx = 4'hF;
        vecs[2].line = {1'b1, 8'hBE, 32'hA5A5BEFC, 32'hA5A5BEF8, 32'hA5A5BEF4, 32'hA5A5BEF0};

        vecs[3].addr = 16'h00FF; vecs[3].wait_cycles = 1;
        vecs[3].seq  = {16'h00F8, 16'h00F4, 16'h00F0, 16'h00FC};
        vecs[3].crit_cyc = 3; vecs[3].crit = 32'hA5A500FC; vecs[3].fill_cyc = 9; vecs[3].idx = 4'hF;
        vecs[3].line = {1'b1, 8'h00, 32'hA5A500FC, 32'hA5A500F8, 32'hA5A500F4, 32'hA5A500F0};

        rst_n = 1'b0;
        bus.miss_valid = 1'b0;
        bus.miss_addr  = '0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = '0;
        repeat (2) @(negedge clk);
        check_reset("rst");
        rst_n = 1'b1;

        // Spurious read data while idle must not move the controller
        spur = 1'b1;
        repeat (3) begin
            @(negedge clk);
            ram_step();
        end
        @(negedge clk);
        chk("idle_spur_stall", 137'(bus.stall),      137'(1'b0));
        chk("idle_spur_req",   137'(bus.mem_req),    137'(1'b0));
        chk("idle_spur_crit",  137'(bus.crit_valid), 137'(1'b0));
        chk("idle_spur_fill",  137'(bus.fill_valid), 137'(1'b0));
        spur = 1'b0;
        ram_step();

        for (int i = 0; i < 4; i++) begin
            run_vector(i, vecs[i]);
        end

        // Back-pressure: second miss held through the refill, spurious rvalid in FILL/IDLE
        wait_cfg = 0;
        @(negedge clk);
        bus.miss_valid = 1'b1;
        bus.miss_addr  = 16'h1230;
        spur = 1'b1;
        ram_step();
        @(posedge clk);
        rdy = '0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            bus.miss_addr = 16'h45E9;
            rdy[c] = bus.miss_ready;
            ram_step();
        end
        chk("bp_ready_pattern", 137'(rdy[6:1]), 137'(6'b100000));
        @(negedge clk);
        chk("bp_second_req",  137'(bus.mem_req),  137'(1'b1));
        chk("bp_second_addr", 137'(bus.mem_addr), 137'(16'h45E8));
        bus.miss_valid = 1'b0;
        spur = 1'b0;
        ram_step();
        fill_cyc = 0; line_got = '0; idx_got = '0; crit_got = '0;
        for (int c = 2; c <= 20 && fill_cyc == 0; c++) begin
            @(negedge clk);
            if (bus.crit_valid) crit_got = bus.crit_data;
            if (bus.fill_valid) begin
                fill_cyc = c;
                line_got = bus.fill_line;
                idx_got  = bus.fill_index;
            end
            ram_step();
        end
        chk("bp_crit_data",  137'(crit_got), 137'(32'hA5A545E8));
        chk("bp_fill_cyc",   137'(fill_cyc), 137'(5));
        chk("bp_fill_index", 137'(idx_got),  137'(4'hE));
        chk("bp_fill_line",  line_got, vecs[1].line);

        // Reset in the middle of a fetch, after three beats
        @(negedge clk);
        bus.miss_valid = 1'b1;
        bus.miss_addr  = 16'hBEF4;
        ram_step();
        @(posedge clk);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            bus.miss_valid = 1'b0;
            ram_step();
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset("midrst");
        ram_step();
        fill_seen = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (bus.fill_valid) fill_seen = 1'b1;
            ram_step();
        end
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (bus.fill_valid) fill_seen = 1'b1;
            ram_step();
        end
        chk("midrst_no_fill", 137'(fill_seen), 137'(1'b0));
        chk("midrst_idle",    137'(bus.miss_ready), 137'(1'b1));
        run_vector(4, vecs[0]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/cache_refill_ctrl.md
# cache_refill_ctrl

Miss-handling stage that sits directly downstream of the direct-mapped data cache, between the cache and the byte-addressed main RAM. On a read miss it fetches the four-word line from RAM critical-word-first with wrap-around and forwards the critical word to the core early. It then writes the assembled 137-bit line (valid bit, tag, four words) back into the cache in one cycle. It stalls the core for the whole refill.

## Interface
- ADDRESS_WIDTH, 16: byte address; A[15:8] tag, A[7:4] index, A[3:2] word offset, A[1:0] byte offset.
- DATA_WIDTH, 32: RAM word width.
- TAG_WIDTH, 8: tag bits.
- INDEX_WIDTH, 4: cache index bits (16 lines).
- LINE_WIDTH, 137: 1 valid + TAG_WIDTH + 4*DATA_WIDTH.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- miss_valid  in  1  cache reports a read miss; held with miss_addr until accepted.
- miss_addr  in  ADDRESS_WIDTH  missing byte address.
- miss_ready  out  1  high only in IDLE; a miss is accepted on an edge where miss_valid & miss_ready.
- stall  out  1  high in every state except IDLE.
- mem_req  out  1  read request to RAM, held high for the entire FETCH state.
- mem_addr  out  ADDRESS_WIDTH  word-aligned beat address {tag, index, beat, 2'b00}.
- mem_rvalid  in  1  RAM returns mem_rdata for the current mem_addr; sampled only while mem_req is high.
- mem_rdata  in  DATA_WIDTH  RAM read word.
- crit_valid  out  1  one-cycle pulse: critical word available.
- crit_data  out  DATA_WIDTH  critical word; holds its value until the next crit_valid.
- fill_valid  out  1  one-cycle pulse: write fill_line into the cache at fill_index.
- fill_index  out  INDEX_WIDTH  cache index of the line.
- fill_line  out  LINE_WIDTH  {1'b1, tag, w3, w2, w1, w0}; wN is the word at offset N.

## Operation
- States: IDLE, FETCH, FILL.
- IDLE: on accept, latch the tag, the index and start = miss_addr[3:2]; clear the beat count and the word-valid mask; go to FETCH.
- FETCH: mem_addr = {tag, index, start+beat (mod 4), 2'b00}.
  - On each mem_rvalid, store mem_rdata into word slot (start+beat) mod 4 and increment the beat count.
  - On the rvalid of beat 0, register crit_data = mem_rdata and pulse crit_valid on the next cycle.
  - On the rvalid of beat 3, go to FILL.
- FILL: assert fill_valid for exactly one cycle, then go to IDLE.
- Wrap-around: a start of 2 gives the fetch order 2, 3, 0, 1. The slot position in fill_line depends only on offset, never on fetch order.
- Ignored inputs:
  - mem_rvalid in IDLE or FILL.
  - miss_valid in FETCH or FILL (miss_ready low). A miss presented during FILL is accepted in the first IDLE cycle.
- miss_addr[1:0] is ignored. The block always fetches whole words.
- Reset (asynchronous, any state, including mid-FETCH): state IDLE; the partial line is discarded and no fill_valid is produced.
- Reset values: miss_ready=1 (in reset to IDLE), stall=0, mem_req=0, mem_addr=0, crit_valid=0, crit_data=0, fill_valid=0, fill_index=0, fill_line=0.

## Timing
- All outputs except miss_ready and stall are registered. miss_ready and stall decode the state register directly.
- Accept at edge 0 puts the block in FETCH in cycle 1, with mem_req=1 and mem_addr on beat 0.
- RAM may assert mem_rvalid in the same cycle as the request (zero wait) or any number of cycles later. mem_addr advances on the edge that samples mem_rvalid.
- Zero-wait timing:
  - Beats sampled at the ends of cycles 1–4.
  - crit_valid in cycle 2.
  - fill_valid in cycle 5.
  - IDLE with miss_ready=1 in cycle 6.
- Minimum miss-to-miss throughput is 6 cycles. Each memory wait cycle adds one cycle.
- fill_line and fill_index are stable during the fill_valid cycle and hold afterwards until the next fill.

## Test plan
- Aligned miss, zero-wait: miss_addr=0x1230, RAM words 0x1230..0x123C = A0, A1, A2, A3.
  - mem_addr sequence 0x1230, 0x1234, 0x1238, 0x123C.
  - crit_data=A0 in cycle 2; fill_valid in cycle 5 with fill_index=3 and fill_line={1, 0x12, A3, A2, A1, A0}.
- Wrap-around: miss_addr=0x45E9.
  - mem_addr sequence 0x45E8, 0x45EC, 0x45E0, 0x45E4.
  - crit_data = word at 0x45E8; fill_index=0xE; slots are ordered by offset.
- Wait states: rvalid delayed 3 cycles on every beat. fill_valid appears in cycle 17, stall is high in cycles 1–17, and mem_addr holds steady during the waits.
- Back-pressure: miss_valid held high throughout a refill with a second address. It is accepted only in the first IDLE cycle, and spurious mem_rvalid in IDLE does not change state.
- Reset mid-operation: rst_n low after beat 2 of a miss.
  - All outputs are at their reset values immediately, with no fill_valid.
  - After reset release, a new miss completes normally.
